// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM states,
// register addresses and status bit positions.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    PLLRST   = 2'd0,
    WAITLOCK = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } state_e;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] MASK    = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;

  localparam int ST_LK      = 0;
  localparam int ST_STATE   = 1;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_LOSS    = 8;

  localparam int CTL_SWRST  = 0;
  localparam int CTL_TOCLR  = 1;

endpackage

// File: rtl/pll_rst_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module pll_rst_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor releasing NUM_CH reset domains in order, with an
// Avalon-MM status/control slave. Define PLL_RST_LOSS_CNT_EN for the lock-loss counter.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 10,
  parameter int PLL_RST_CYC  = 8,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int HOLD_DEFAULT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  input  logic              pll_locked,
  output logic              pll_areset,
  output logic [NUM_CH-1:0] rst_out,
  output logic              resetrequest
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, hold, hold_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [NUM_CH-1:0] mask, mask_nxt, rst_nxt;
  logic              lk, timeout, timeout_nxt;
  logic              wr, sw_rst, lock_loss;
  logic [7:0]        loss_cnt;
  logic              unused_ok;

  assign unused_ok = ^{read, writedata};

  pll_rst_sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lk)
  );

  assign wr        = chipselect && write;
  assign sw_rst    = wr && (address == CONTROL) && writedata[CTL_SWRST];
  assign lock_loss = !lk && ((state == RELEASE) || (state == RUN));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    rst_nxt     = rst_out;
    timeout_nxt = timeout;
    mask_nxt    = mask;
    hold_nxt    = hold;
    if (wr && address == MASK)    mask_nxt = writedata[NUM_CH-1:0];
    if (wr && address == HOLD)    hold_nxt = writedata[CNT_W-1:0];
    if (wr && address == CONTROL && writedata[CTL_TOCLR]) timeout_nxt = 1'b0;
    unique case (state)
      PLLRST: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAITLOCK;
          cnt_nxt   = '0;
        end
      end
      WAITLOCK: begin
        if (lk) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = PLLRST;
          cnt_nxt     = '0;
        end
      end
      RELEASE: begin
        // >= keeps a mid-sequence hold reduction from wrapping the counter
        if (cnt >= hold) begin
          cnt_nxt = '0;
          if (!mask[idx]) rst_nxt[idx] = 1'b0;
          if (idx == IDX_LAST) state_nxt = RUN;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        rst_nxt = mask_nxt;
      end
      default: state_nxt = PLLRST;
    endcase
    // Software reset and lock loss merge into one restart
    if (sw_rst || lock_loss) begin
      state_nxt = PLLRST;
      cnt_nxt   = '0;
    end
    if (state_nxt == PLLRST) rst_nxt = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PLLRST;
      cnt          <= '0;
      idx          <= '0;
      rst_out      <= '1;
      pll_areset   <= 1'b1;
      resetrequest <= 1'b1;
      timeout      <= 1'b0;
      mask         <= '0;
      hold         <= CNT_W'(HOLD_DEFAULT);
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      rst_out      <= rst_nxt;
      pll_areset   <= (state_nxt == PLLRST);
      resetrequest <= (state_nxt != RUN);
      timeout      <= timeout_nxt;
      mask         <= mask_nxt;
      hold         <= hold_nxt;
    end
  end

`ifdef PLL_RST_LOSS_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            loss_cnt <= '0;
    else if (lock_loss && loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
  end
`else
  assign loss_cnt = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      STATUS: begin
        readdata[ST_LK]          = lk;
        readdata[ST_STATE +: 2]  = state;
        readdata[ST_TIMEOUT]     = timeout;
        readdata[ST_LOSS +: 8]   = loss_cnt;
      end
      MASK:    readdata[NUM_CH-1:0] = mask;
      HOLD:    readdata[CNT_W-1:0]  = hold;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: table-driven release timing plus
// hand-written lock-loss, software-reset, timeout and async-reset sequences.
module tb_pll_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, read, write;
  logic [15:0] writedata, readdata;
  logic        pll_locked, pll_areset, resetrequest;
  logic [3:0]  rst_out;

  pll_reset_sequencer dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .pll_locked(pll_locked), .pll_areset(pll_areset), .rst_out(rst_out),
    .resetrequest(resetrequest)
  );

  always #5 clk = ~clk;

`ifdef PLL_RST_LOSS_CNT_EN
  localparam int LOSS_INC = 1;
`else
  localparam int LOSS_INC = 0;
`endif

  typedef struct {
    int         cyc;
    logic       pa;
    logic [3:0] rst;
    logic       rr;
  } vec_t;

  vec_t pu [11];
  vec_t sq [8];
  int   errs = 0, checks = 0, cyc = 0, exp_loss = 0, t0, base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] e);
    address = a; read = 1'b1;
    #1;
    chk(name, readdata, e);
    address = '0; read = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick();
    address = '0; writedata = '0; chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic chk_vec(input string tag, input int i, input vec_t v);
    chk($sformatf("%s%0d_pll_areset", tag, i), pll_areset, v.pa);
    chk($sformatf("%s%0d_rst_out", tag, i), rst_out, v.rst);
    chk($sformatf("%s%0d_resetrequest", tag, i), resetrequest, v.rr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    // power-up, hold=16: release at 26, then every 17 cycles
    pu[0]  = '{0,  1'b1, 4'hF, 1'b1};
    pu[1]  = '{7,  1'b1, 4'hF, 1'b1};
    pu[2]  = '{8,  1'b0, 4'hF, 1'b1};
    pu[3]  = '{25, 1'b0, 4'hF, 1'b1};
    pu[4]  = '{26, 1'b0, 4'hE, 1'b1};
    pu[5]  = '{42, 1'b0, 4'hE, 1'b1};
    pu[6]  = '{43, 1'b0, 4'hC, 1'b1};
    pu[7]  = '{59, 1'b0, 4'hC, 1'b1};
    pu[8]  = '{60, 1'b0, 4'h8, 1'b1};
    pu[9]  = '{76, 1'b0, 4'h8, 1'b1};
    pu[10] = '{77, 1'b0, 4'h0, 1'b0};
    // software reset with hold=0, mask=0x4, offsets from the control write
    sq[0]  = '{0,  1'b1, 4'hF, 1'b1};
    sq[1]  = '{7,  1'b1, 4'hF, 1'b1};
    sq[2]  = '{8,  1'b0, 4'hF, 1'b1};
    sq[3]  = '{9,  1'b0, 4'hF, 1'b1};
    sq[4]  = '{10, 1'b0, 4'hE, 1'b1};
    sq[5]  = '{11, 1'b0, 4'hC, 1'b1};
    sq[6]  = '{12, 1'b0, 4'hC, 1'b1};
    sq[7]  = '{13, 1'b0, 4'h4, 1'b0};

    reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; pll_locked = 1'b1;
    #1;
    chk("reset_pll_areset", pll_areset, 1);
    chk("reset_rst_out", rst_out, 4'hF);
    chk("reset_resetrequest", resetrequest, 1);
    rd_chk("reset_status", 3'd0, 16'h0000);
    rd_chk("reset_hold", 3'd3, 16'd16);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; cyc = 0;

    for (int i = 0; i < 11; i++) begin
      run_to(pu[i].cyc);
      chk_vec("pu", i, pu[i]);
    end
    rd_chk("run_status", 3'd0, 16'h0007);
    rd_chk("run_mask", 3'd2, 16'h0000);
    rd_chk("run_ctrl_reads0", 3'd1, 16'h0000);
    rd_chk("unmapped_5", 3'd5, 16'h0000);

    // lock lost for 5 cycles in RUN
    pll_locked = 1'b0; t0 = cyc;
    tick(); tick();
    chk("loss_rst_still_low", rst_out, 4'h0);
    tick();
    chk("loss_rst_high", rst_out, 4'hF);
    chk("loss_pll_areset", pll_areset, 1);
    exp_loss += LOSS_INC;
    rd_chk("loss_count", 3'd0, 16'(exp_loss << 8));
    tick(); tick();
    pll_locked = 1'b1;
    while (resetrequest !== 1'b0 && cyc - t0 < 200) tick();
    chk("relock_time", cyc - t0, 80);
    chk("relock_rst_out", rst_out, 4'h0);

    // masked channel keeps its slot but stays in reset
    wr_reg(3'd2, 16'h0004);
    chk("run_mask_write", rst_out, 4'h4);
    wr_reg(3'd3, 16'h0000);
    rd_chk("hold_zero", 3'd3, 16'h0000);
    wr_reg(3'd1, 16'h0001);
    base = cyc;
    for (int i = 0; i < 8; i++) begin
      run_to(base + sq[i].cyc);
      chk_vec("sq", i, sq[i]);
    end
    wr_reg(3'd2, 16'h0000);
    chk("unmask_next_cycle", rst_out, 4'h0);
    rd_chk("loss_unchanged_by_swrst", 3'd0, 16'(16'h0007 | (exp_loss << 8)));

    // software reset lands in the same cycle lk falls
    pll_locked = 1'b0;
    tick(); tick();
    wr_reg(3'd1, 16'h0001);
    exp_loss += LOSS_INC;
    rd_chk("sim_swrst_loss", 3'd0, 16'(exp_loss << 8));
    chk("sim_rst_out", rst_out, 4'hF);
    pll_locked = 1'b1; t0 = cyc;
    while (resetrequest !== 1'b0 && cyc - t0 < 100) tick();
    chk("sim_recovered_rr", resetrequest, 0);
    chk("sim_recovered_rst", rst_out, 4'h0);

    // async reset while in RELEASE
    wr_reg(3'd2, 16'h0002);
    wr_reg(3'd3, 16'h0003);
    wr_reg(3'd1, 16'h0001);
    run_to(cyc + 13);
    rd_chk("midrel_status", 3'd0, 16'(16'h0005 | (exp_loss << 8)));
    chk("midrel_rst_out", rst_out, 4'hE);
    #2 reset = 1'b1;
    #1;
    chk("areset_pll_areset", pll_areset, 1);
    chk("areset_rst_out", rst_out, 4'hF);
    chk("areset_resetrequest", resetrequest, 1);
    rd_chk("areset_hold", 3'd3, 16'd16);
    rd_chk("areset_mask", 3'd2, 16'h0000);
    rd_chk("areset_status", 3'd0, 16'h0000);

    // lock timeout with pll_locked held low
    pll_locked = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; cyc = 0;
    run_to(1007);
    rd_chk("to_waitlock", 3'd0, 16'h0002);
    chk("to_waitlock_pa", pll_areset, 0);
    tick();
    rd_chk("to_sticky", 3'd0, 16'h0008);
    chk("to_pa", pll_areset, 1);
    wr_reg(3'd1, 16'h0002);
    rd_chk("to_cleared", 3'd0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
